// File: rtl/edge_pkg.sv
// Shared pixel and neighbourhood types for the edge-detection pipeline.
package edge_pkg;

   localparam int unsigned PIXEL_W = 8;
   localparam int unsigned COORD_W = 16;

   typedef logic [PIXEL_W-1:0] pixel_t;

   // Element k is byte k of the 3x3 window: 0 top-left, 4 centre, 8 bottom-right.
   typedef pixel_t [8:0] window_t;

endpackage : edge_pkg

// File: rtl/line_buffer.sv
// One image row of pixel storage; the read at addr returns the old value during a write.
module line_buffer
   import edge_pkg::*;
#(
   parameter int unsigned DEPTH = 640,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  pixel_t        wdata,
   output pixel_t        rdata
);

   pixel_t mem_q [DEPTH];

   // Storage write; contents are not reset since every cell is rewritten before use.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

   assign rdata = mem_q[addr];

endmodule : line_buffer

// File: rtl/pixel_window.sv
// Raster-order pixel stream to registered 3x3 neighbourhood with centre coordinates.
module pixel_window
   import edge_pkg::*;
#(
   parameter int unsigned IMG_WIDTH  = 640,
   parameter int unsigned IMG_HEIGHT = 480
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        clear,
   input  logic        pixel_valid,
   input  logic [7:0]  pixel_in,
   output logic [71:0] window,
   output logic        window_valid,
   output logic [15:0] center_x,
   output logic [15:0] center_y,
   output logic        frame_done
);

   localparam int unsigned AW = $clog2(IMG_WIDTH);
   localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(IMG_WIDTH - 1);
   localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(IMG_HEIGHT - 1);

   logic [COORD_W-1:0] col_q, col_d;
   logic [COORD_W-1:0] row_q, row_d;
   logic [COORD_W-1:0] center_x_q, center_x_d;
   logic [COORD_W-1:0] center_y_q, center_y_d;
   window_t            win_q, win_d;
   logic               window_valid_q, window_valid_d;
   logic               frame_done_q, frame_done_d;

   logic               accept_c;
   pixel_t             line1_rd;
   pixel_t             line2_rd;

   // clear has priority over an incoming pixel
   assign accept_c = pixel_valid & ~clear;

   // line1 holds row r-1, line2 holds row r-2
   line_buffer #(.DEPTH(IMG_WIDTH), .AW(AW)) u_line1 (
      .clk   (clk),
      .we    (accept_c),
      .addr  (AW'(col_q)),
      .wdata (pixel_in),
      .rdata (line1_rd)
   );

   line_buffer #(.DEPTH(IMG_WIDTH), .AW(AW)) u_line2 (
      .clk   (clk),
      .we    (accept_c),
      .addr  (AW'(col_q)),
      .wdata (line1_rd),
      .rdata (line2_rd)
   );

   // Next-state: raster counters, window shift, and per-accept status pulses
   always_comb begin
      col_d          = col_q;
      row_d          = row_q;
      win_d          = win_q;
      center_x_d     = center_x_q;
      center_y_d     = center_y_q;
      window_valid_d = 1'b0;
      frame_done_d   = 1'b0;

      if (clear) begin
         col_d = '0;
         row_d = '0;
      end else if (pixel_valid) begin
         for (int r = 0; r < 3; r++) begin
            win_d[3*r]     = win_q[3*r + 1];
            win_d[3*r + 1] = win_q[3*r + 2];
         end
         win_d[2] = line2_rd;
         win_d[5] = line1_rd;
         win_d[8] = pixel_in;

         // Columns 0 and 1 would mix the previous row's tail into the window
         window_valid_d = (col_q >= COORD_W'(2)) && (row_q >= COORD_W'(2));
         if (window_valid_d) begin
            center_x_d = col_q - COORD_W'(1);
            center_y_d = row_q - COORD_W'(1);
         end

         frame_done_d = (col_q == COL_LAST) && (row_q == ROW_LAST);

         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + COORD_W'(1);
         end else begin
            col_d = col_q + COORD_W'(1);
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         col_q          <= '0;
         row_q          <= '0;
         win_q          <= '0;
         center_x_q     <= '0;
         center_y_q     <= '0;
         window_valid_q <= 1'b0;
         frame_done_q   <= 1'b0;
      end else begin
         col_q          <= col_d;
         row_q          <= row_d;
         win_q          <= win_d;
         center_x_q     <= center_x_d;
         center_y_q     <= center_y_d;
         window_valid_q <= window_valid_d;
         frame_done_q   <= frame_done_d;
      end
   end

   assign window       = win_q;
   assign window_valid = window_valid_q;
   assign center_x     = center_x_q;
   assign center_y     = center_y_q;
   assign frame_done   = frame_done_q;

endmodule : pixel_window
